alu_iterative: RTL

Parametrised execute-stage ALU replacing the single-cycle combinational ALU. It keeps the EX/MEM forwarding operand select and the single-cycle logic/add/sub operations. It adds an iterative shift-add multiplier, an optional restoring divider and a signed set-less-than, behind a valid/ready handshake so the pipeline can stall on multi-cycle operations. It sits between the ID/EX register and the EX/MEM register, with the hazard unit driving the forward selects.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_iterative_if.sv | 29 ++
 rtl/alu_fwd_mux.sv | 23 ++
 rtl/alu_iterative.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and forward-select bit positions for alu_iterative.
// Optional divider datapath is controlled by the ALU_DIV_EN macro.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_DIV = 3'b100;
    localparam logic [2:0] ALU_REM = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam int FWD_EX  = 1;
    localparam int FWD_MEM = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_iterative_if.sv
// Request/response bundle between the pipeline (master) and alu_iterative (slave).
interface alu_iterative_if #(parameter int WIDTH = 32);

    logic             valid_i;
    logic             ready_o;
    logic             flush_i;
    logic [2:0]       ALUCtrl_i;
    logic [1:0]       ForwardRs_i;
    logic [1:0]       ForwardRt_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [WIDTH-1:0] ExData_i;
    logic [WIDTH-1:0] MemData_i;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;

    modport master (
        output valid_i, flush_i, ALUCtrl_i, ForwardRs_i, ForwardRt_i,
               data1_i, data2_i, ExData_i, MemData_i,
        input  ready_o, data_o, valid_o
    );

    modport slave (
        input  valid_i, flush_i, ALUCtrl_i, ForwardRs_i, ForwardRt_i,
               data1_i, data2_i, ExData_i, MemData_i,
        output ready_o, data_o, valid_o
    );

endinterface

// File: rtl/alu_fwd_mux.sv
// Operand forward select: EX result beats MEM result, which beats the register value.
module alu_fwd_mux
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] reg_i,
    input  logic [WIDTH-1:0] ex_i,
    input  logic [WIDTH-1:0] mem_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = reg_i;
        if (sel_i[FWD_EX]) begin
            data_o = ex_i;
        end else if (sel_i[FWD_MEM]) begin
            data_o = mem_i;
        end
    end

endmodule

// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle logic/arith, iterative shift-add multiply and
// (with ALU_DIV_EN defined) restoring divide, behind a valid/ready handshake.
module alu_iterative
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    alu_iterative_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, data_q, data_d;
    logic             done_q, done_d, valid_q, valid_d;
    logic [WIDTH-1:0] rs_fwd, rt_fwd, result;
    logic             accept;

    alu_fwd_mux #(.WIDTH(WIDTH)) u_fwd_rs (
        .sel_i (bus.ForwardRs_i),
        .reg_i (bus.data1_i),
        .ex_i  (bus.ExData_i),
        .mem_i (bus.MemData_i),
        .data_o(rs_fwd)
    );

    alu_fwd_mux #(.WIDTH(WIDTH)) u_fwd_rt (
        .sel_i (bus.ForwardRt_i),
        .reg_i (bus.data2_i),
        .ex_i  (bus.ExData_i),
        .mem_i (bus.MemData_i),
        .data_o(rt_fwd)
    );

    assign accept      = bus.valid_i && (state_q == S_IDLE) && !bus.flush_i;
    assign bus.ready_o = (state_q == S_IDLE);
    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;

`ifdef ALU_DIV_EN
    // a_q shifts dividend bits out and quotient bits in; acc_q is the partial remainder.
    logic [WIDTH:0] rem_shift, rem_diff;
    assign rem_shift = {acc_q, a_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, b_q};
`endif

    // Result is formed from the latched operands in the cycle after completion.
    always_comb begin
        result = '0;
        case (op_q)
            ALU_AND: result = a_q & b_q;
            ALU_OR:  result = a_q | b_q;
            ALU_ADD: result = a_q + b_q;
            ALU_SUB: result = a_q - b_q;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            ALU_MUL: result = acc_q;
`ifdef ALU_DIV_EN
            ALU_DIV: result = a_q;
            ALU_REM: result = acc_q;
`endif
            default: result = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        if (done_q) begin
            data_d  = result;
            valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = bus.ALUCtrl_i;
                    a_d   = rs_fwd;
                    b_d   = rt_fwd;
                    acc_d = '0;
                    cnt_d = '0;
                    if (bus.ALUCtrl_i == ALU_MUL) begin
                        state_d = S_MUL;
`ifdef ALU_DIV_EN
                    end else if (bus.ALUCtrl_i == ALU_DIV || bus.ALUCtrl_i == ALU_REM) begin
                        state_d = S_DIV;
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
                // Divisor zero never borrows: quotient all ones, remainder the dividend.
                if (!rem_diff[WIDTH]) begin
                    acc_d = rem_diff[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_shift[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (bus.flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            valid_d = 1'b0;
            data_d  = data_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= ALU_AND;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

endmodule
